// File: rtl/pc_fetch.sv
// Program counter and instruction-fetch sequencer: drives the PC+4 adder, picks redirects,
// runs the imem req/ack handshake and registers fetched words for decode (ack-to-valid 1 cycle).
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] pc_o,
  input  logic [31:0] seq_next_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic        jmp_i,
  input  logic [31:0] jmp_target_i,
  input  logic        stall_i,
  input  logic        halt_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_valid_o,
  output logic        halted_o,
  output logic        addr_err_o
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic        addr_err_q, addr_err_d;
  logic        pend_vld_q, pend_vld_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        halt_pend_q, halt_pend_d;

  logic        req;
  logic        redir;
  logic [31:0] redir_raw;
  logic [31:0] redir_tgt;
  logic        redir_misaligned;
  logic        halt_seen;

  // jmp outranks br_taken when both arrive together
  assign redir            = jmp_i | br_taken_i;
  assign redir_raw        = jmp_i ? jmp_target_i : br_target_i;
  assign redir_tgt        = {redir_raw[31:2], 2'b00};
  assign redir_misaligned = redir && (redir_raw[1:0] != 2'b00);
  assign halt_seen        = halt_i | halt_pend_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = 1'b0;
    addr_err_d   = 1'b0;
    pend_vld_d   = pend_vld_q;
    pend_pc_d    = pend_pc_q;
    halt_pend_d  = halt_pend_q;
    req          = 1'b0;

    case (state_q)
      S_BOOT: begin
        if (redir) begin
          pc_d       = redir_tgt;
          addr_err_d = redir_misaligned;
        end
        state_d = halt_i ? S_HALT : S_FETCH;
      end

      S_FETCH: begin
        req        = !stall_i;
        addr_err_d = redir_misaligned;
        if (req && imem_ack_i) begin
          // a pending redirect means this word belongs to a dead path
          inst_d       = imem_rdata_i;
          inst_pc_d    = pc_q;
          inst_valid_d = !pend_vld_q;
          if (pend_vld_q)  pc_d = pend_pc_q;
          else if (redir)  pc_d = redir_tgt;
          else             pc_d = seq_next_i;
          pend_vld_d = 1'b0;
        end else if (req) begin
          if (redir) begin
            pend_vld_d = 1'b1;
            pend_pc_d  = redir_tgt;
          end
        end else begin
          // nothing in flight: redirects take effect on the pc directly
          if (redir) begin
            pc_d       = redir_tgt;
            pend_vld_d = 1'b0;
          end else if (pend_vld_q) begin
            pc_d       = pend_pc_q;
            pend_vld_d = 1'b0;
          end
        end

        if (halt_seen && !(req && !imem_ack_i)) begin
          state_d     = S_HALT;
          halt_pend_d = 1'b0;
        end else begin
          halt_pend_d = halt_seen;
        end
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_PC;
      inst_q       <= 32'h0;
      inst_pc_q    <= 32'h0;
      inst_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
      pend_vld_q   <= 1'b0;
      pend_pc_q    <= 32'h0;
      halt_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      addr_err_q   <= addr_err_d;
      pend_vld_q   <= pend_vld_d;
      pend_pc_q    <= pend_pc_d;
      halt_pend_q  <= halt_pend_d;
    end
  end

  assign pc_o         = pc_q;
  assign imem_addr_o  = pc_q;
  assign imem_req_o   = req;
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;
  assign inst_valid_o = inst_valid_q;
  assign addr_err_o   = addr_err_q;
  assign halted_o     = (state_q == S_HALT);

endmodule
